mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control FSM that sequences the execute datapath (operand-B mux + ALU) and the surrounding fetch/regfile/data-memory strobes, one RV32I instruction at a time.
- Decodes the latched instruction fields.
- Drives alub_sel/alu_op into the execute stage and resolves branches from the ALU zero/sign flags.
- Stalls on instruction-ROM and data-RAM ready handshakes.

Parameters:
- RST_PC_HOLD, 1, when 1 pc_we is held 0 for the first IF after reset release, even if irom_ready is high.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  inst[6:0] from IR
- funct3  in  3  inst[14:12] from IR
- funct7_5  in  1  inst[30] from IR
- irom_ready  in  1  instruction word valid this cycle
- dram_ready  in  1  data access completes this cycle
- alu_zero  in  1  ALU result == 0
- alu_sgn  in  1  ALU result[31]
- ir_we  out  1  latch instruction register
- pc_we  out  1  update PC
- npc_op  out  2  next-PC select
- rf_we  out  1  register-file write
- wd_sel  out  2  writeback select
- dram_we  out  1  data-RAM write strobe
- dram_re  out  1  data-RAM read strobe
- alub_sel  out  1  ALU B source: ALU_B_RF_RD2 or ALU_B_SEXT_EXT
- alu_op  out  4  ALU operation
- illegal  out  1  one-cycle pulse on undecodable opcode
- retire  out  1  one-cycle pulse when an instruction completes

Behaviour:
- Reset: rst_n low asynchronously forces state=S_IF. All outputs are 0 while rst_n=0, including ir_we, even if irom_ready=1.
- States: S_IF, S_ID, S_EX, S_MEM, S_WB. The state register is 3 bits; unused encodings return to S_IF.
- Outputs are combinational from state, decoded class and flags. Only the state register is sequential.
- S_IF:
  - ir_we = irom_ready.
  - Advance to S_ID when irom_ready=1; otherwise hold with no strobes.
- S_ID:
  - One cycle, no strobes except illegal.
  - Opcode outside {R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111}: illegal=1, pc_we=1, npc_op=NPC_PC4, retire=1, go to S_IF.
  - Otherwise go to S_EX.
- S_EX, alu_op / alub_sel by class:
  - R: alub_sel=RF_RD2. alu_op from funct3 and funct7_5: 000 → ADD, or SUB if funct7_5=1; 001 → SLL; 100 → XOR; 101 → SRL, or SRA if funct7_5=1; 110 → OR; 111 → AND. funct3 010/011 → illegal path (same as S_ID illegal).
  - I: alub_sel=SEXT_EXT. Same funct3 map, except funct3=000 is always ADD. funct7_5 selects SRA only for funct3=101.
  - LOAD, STORE, JALR: ADD with SEXT_EXT.
  - BRANCH: SUB with RF_RD2.
  - LUI, JAL: ADD with SEXT_EXT; the result is unused.
- S_EX, branch resolution:
  - Taken = beq: zero; bne: !zero; blt: sgn; bge: !sgn. Other funct3 values are not taken.
  - pc_we=1, npc_op = taken ? NPC_PCIMM : NPC_PC4, retire=1, go to S_IF.
- S_EX next state: LOAD/STORE → S_MEM; all others → S_WB.
- S_MEM:
  - LOAD: dram_re=1. STORE: dram_we=1.
  - Hold until dram_ready=1.
  - On ready: LOAD → S_WB; STORE → pc_we=1, npc_op=PC4, retire=1, go to S_IF.
- S_WB:
  - rf_we=1, pc_we=1, retire=1, go to S_IF.
  - wd_sel: R/I → WD_ALU; LOAD → WD_DRAM; JAL/JALR → WD_PC4; LUI → WD_IMM.
  - npc_op: JAL → NPC_PCIMM; JALR → NPC_ALU; others → NPC_PC4.
- Latency with ready signals held high: R/I/LUI/JAL/JALR 4 cycles, LOAD 5, STORE 4, BRANCH 3, illegal 2.
- Each wait cycle in S_IF or S_MEM adds one cycle.
- RST_PC_HOLD applies only to the first S_IF after reset release and has no effect afterwards.
- Stall invariants: during a stall, strobes stay asserted and alu_op is stable. No write enable is ever asserted in two different states for the same instruction.

Decomposition:
- Shared package (param):
  - Existing ALU_B_RF_RD2=0 and ALU_B_SEXT_EXT=1.
  - ALU ops: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7.
  - Opcode constants.
  - NPC_PC4=0, NPC_PCIMM=1, NPC_ALU=2.
  - WD_ALU=0, WD_DRAM=1, WD_PC4=2, WD_IMM=3.
  - State encodings.
- Sub-module mc_alu_dec: purely combinational class/funct → alu_op, alub_sel, illegal-funct decode. The FSM stays in mc_ctrl.

Test Plan:
- Reset: rst_n low mid-S_MEM of a STORE → dram_we drops to 0 immediately. After release, state=S_IF and all outputs 0 until irom_ready=1.
- add (opcode 0110011, funct3 000, funct7_5 0), ready high → ir_we cycle 0; EX alu_op=0, alub_sel=0; WB rf_we=1, wd_sel=0, pc_we=1. retire at cycle 3.
- sub / srai / slli: funct7_5=1 R-type → alu_op=1. I-type funct3=101, funct7_5=1 → alu_op=7, alub_sel=1. I-type funct3=000, funct7_5=1 → alu_op=0.
- beq with alu_zero=1 → EX pc_we=1, npc_op=1, retire at cycle 2. bge with alu_sgn=1 → npc_op=0.
- lw with dram_ready low 3 cycles → dram_re high 4 cycles, then WB wd_sel=1; total 8 cycles. sw → dram_we stretches identically, no rf_we.
- Illegal opcode 0000000 → illegal=1 in S_ID, pc_we=1, npc_op=0, no rf_we/dram_we. R-type funct3=010 → illegal in S_EX.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle control FSM
package mc_ctrl_pkg;

   // ALU operand-B source
   localparam logic ALU_B_RF_RD2   = 1'b0;
   localparam logic ALU_B_SEXT_EXT = 1'b1;

   // ALU operations
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6;
   localparam logic [3:0] ALU_SRA = 4'd7;

   // RV32I major opcodes handled by this core
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // Next-PC select
   localparam logic [1:0] NPC_PC4   = 2'd0;
   localparam logic [1:0] NPC_PCIMM = 2'd1;
   localparam logic [1:0] NPC_ALU   = 2'd2;

   // Register-file writeback select
   localparam logic [1:0] WD_ALU  = 2'd0;
   localparam logic [1:0] WD_DRAM = 2'd1;
   localparam logic [1:0] WD_PC4  = 2'd2;
   localparam logic [1:0] WD_IMM  = 2'd3;

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_e;

   typedef enum logic [3:0] {
      CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_LUI, CL_BAD
   } class_e;

   // Reduce the 7-bit opcode to an instruction class; anything unknown is CL_BAD
   function automatic class_e opcode_class(input logic [6:0] op);
      case (op)
         OP_R:      return CL_R;
         OP_I:      return CL_I;
         OP_LOAD:   return CL_LOAD;
         OP_STORE:  return CL_STORE;
         OP_BRANCH: return CL_BRANCH;
         OP_JAL:    return CL_JAL;
         OP_JALR:   return CL_JALR;
         OP_LUI:    return CL_LUI;
         default:   return CL_BAD;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// rtl/mc_ctrl_alu_dec.sv - class/funct to ALU op and operand-B select decode
module mc_alu_dec
   import mc_ctrl_pkg::*;
(
   input  class_e     cls,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [3:0] alu_op,
   output logic       alub_sel,
   output logic       bad_funct
);

   // Address/immediate classes default to ADD with the extended immediate
   always_comb begin
      alu_op    = ALU_ADD;
      alub_sel  = ALU_B_SEXT_EXT;
      bad_funct = 1'b0;
      case (cls)
         CL_R, CL_I: begin
            alub_sel = (cls == CL_R) ? ALU_B_RF_RD2 : ALU_B_SEXT_EXT;
            case (funct3)
               // funct7_5 means SUB only for register-register; addi ignores it
               3'b000:  alu_op = ((cls == CL_R) && funct7_5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_op = ALU_SLL;
               3'b100:  alu_op = ALU_XOR;
               3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_op = ALU_OR;
               3'b111:  alu_op = ALU_AND;
               // funct3 010/011 have no ALU operation and decode as illegal
               default: bad_funct = 1'b1;
            endcase
         end
         CL_BRANCH: begin
            alu_op   = ALU_SUB;
            alub_sel = ALU_B_RF_RD2;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB)
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int RST_PC_HOLD = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       irom_ready,
   input  logic       dram_ready,
   input  logic       alu_zero,
   input  logic       alu_sgn,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] npc_op,
   output logic       rf_we,
   output logic [1:0] wd_sel,
   output logic       dram_we,
   output logic       dram_re,
   output logic       alub_sel,
   output logic [3:0] alu_op,
   output logic       illegal,
   output logic       retire
);

   state_e     state_q, state_d;
   class_e     cls;
   logic [3:0] dec_op;
   logic       dec_sel;
   logic       dec_bad;
   logic       br_taken;

   assign cls = opcode_class(opcode);

   mc_alu_dec u_alu_dec (
      .cls       (cls),
      .funct3    (funct3),
      .funct7_5  (funct7_5),
      .alu_op    (dec_op),
      .alub_sel  (dec_sel),
      .bad_funct (dec_bad)
   );

   // Branch condition from the SUB result flags; unsupported funct3 falls through
   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         3'b000:  br_taken = alu_zero;
         3'b001:  br_taken = ~alu_zero;
         3'b100:  br_taken = alu_sgn;
         3'b101:  br_taken = ~alu_sgn;
         default: br_taken = 1'b0;
      endcase
   end

   // Next state and all strobes, decoded from the current state and latched fields
   always_comb begin
      state_d  = state_q;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      npc_op   = NPC_PC4;
      rf_we    = 1'b0;
      wd_sel   = WD_ALU;
      dram_we  = 1'b0;
      dram_re  = 1'b0;
      alub_sel = ALU_B_RF_RD2;
      alu_op   = ALU_ADD;
      illegal  = 1'b0;
      retire   = 1'b0;
      case (state_q)
         S_IF: begin
            ir_we = irom_ready;
            if (irom_ready) state_d = S_ID;
         end
         S_ID: begin
            if (cls == CL_BAD) begin
               illegal = 1'b1;
               pc_we   = 1'b1;
               retire  = 1'b1;
               state_d = S_IF;
            end else begin
               state_d = S_EX;
            end
         end
         S_EX: begin
            alu_op   = dec_op;
            alub_sel = dec_sel;
            if (dec_bad) begin
               illegal = 1'b1;
               pc_we   = 1'b1;
               retire  = 1'b1;
               state_d = S_IF;
            end else if (cls == CL_BRANCH) begin
               pc_we   = 1'b1;
               npc_op  = br_taken ? NPC_PCIMM : NPC_PC4;
               retire  = 1'b1;
               state_d = S_IF;
            end else if ((cls == CL_LOAD) || (cls == CL_STORE)) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            // Address stays on the ALU for the whole access, stalls included
            alu_op   = dec_op;
            alub_sel = dec_sel;
            dram_re  = (cls == CL_LOAD);
            dram_we  = (cls == CL_STORE);
            if (dram_ready) begin
               if (cls == CL_LOAD) begin
                  state_d = S_WB;
               end else begin
                  pc_we   = 1'b1;
                  retire  = 1'b1;
                  state_d = S_IF;
               end
            end
         end
         S_WB: begin
            alu_op   = dec_op;
            alub_sel = dec_sel;
            rf_we    = 1'b1;
            pc_we    = 1'b1;
            retire   = 1'b1;
            state_d  = S_IF;
            case (cls)
               CL_LOAD: wd_sel = WD_DRAM;
               CL_JAL: begin
                  wd_sel = WD_PC4;
                  npc_op = NPC_PCIMM;
               end
               CL_JALR: begin
                  wd_sel = WD_PC4;
                  npc_op = NPC_ALU;
               end
               CL_LUI:  wd_sel = WD_IMM;
               default: wd_sel = WD_ALU;
            endcase
         end
         default: state_d = S_IF;
      endcase
      // PC only advances at instruction end, so fetch (including the first one
      // after reset) never writes it; the hold keeps that explicit
      if ((RST_PC_HOLD != 0) && (state_q == S_IF)) pc_we = 1'b0;
      // Outputs are combinational, so reset must mask them directly
      if (!rst_n) begin
         ir_we    = 1'b0;
         pc_we    = 1'b0;
         npc_op   = NPC_PC4;
         rf_we    = 1'b0;
         wd_sel   = WD_ALU;
         dram_we  = 1'b0;
         dram_re  = 1'b0;
         alub_sel = ALU_B_RF_RD2;
         alu_op   = ALU_ADD;
         illegal  = 1'b0;
         retire   = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IF;
      else        state_q <= state_d;
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized self-checking bench for mc_ctrl
module tb_mc_ctrl;

   localparam logic [6:0] T_R = 7'b0110011, T_I = 7'b0010011, T_LD = 7'b0000011, T_ST = 7'b0100011;
   localparam logic [6:0] T_BR = 7'b1100011, T_JAL = 7'b1101111, T_JALR = 7'b1100111, T_LUI = 7'b0110111;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5, irom_ready, dram_ready, alu_zero, alu_sgn;
   logic       ir_we, pc_we, rf_we, dram_we, dram_re, alub_sel, illegal, retire;
   logic [1:0] npc_op, wd_sel;
   logic [3:0] alu_op;
   logic [15:0] outs;

   int n_assert = 0;
   int n_fail   = 0;

   // Observations of one instruction
   int o_lat, o_ir, o_ir_cyc, o_pc, o_rf, o_re, o_we, o_ill, o_unstable;
   logic [1:0] o_npc, o_wd;
   logic [3:0] o_alu;
   logic       o_sel;

   typedef struct packed {
      logic [7:0] lat;
      logic       ill;
      logic       rf;
      logic [3:0] re;
      logic [3:0] we;
      logic [1:0] npc;
      logic [1:0] wd;
      logic [3:0] alu;
      logic       sel;
      logic       ex_seen;
   } exp_t;

   always #5 clk = ~clk;

   assign outs = {ir_we, pc_we, npc_op, rf_we, wd_sel, dram_we, dram_re, alub_sel, alu_op, illegal, retire};

   mc_ctrl #(.RST_PC_HOLD(1)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .irom_ready(irom_ready), .dram_ready(dram_ready), .alu_zero(alu_zero), .alu_sgn(alu_sgn),
      .ir_we(ir_we), .pc_we(pc_we), .npc_op(npc_op), .rf_we(rf_we), .wd_sel(wd_sel),
      .dram_we(dram_we), .dram_re(dram_re), .alub_sel(alub_sel), .alu_op(alu_op),
      .illegal(illegal), .retire(retire)
   );

   // Instruction-level reference: cycle budget, strobe counts and final selects
   function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                  input logic z, input logic s, input int if_w, input int mem_w);
      exp_t e;
      e = '0;
      e.ex_seen = 1'b1;
      e.sel = 1'b1;
      case (op)
         T_R, T_I: begin
            if (f3 == 3'd2 || f3 == 3'd3) begin
               e.ill = 1'b1; e.ex_seen = 1'b0; e.lat = 8'(if_w + 3);
            end else begin
               e.rf = 1'b1; e.lat = 8'(if_w + 4); e.sel = (op == T_I);
               if (f3 == 3'd0)      e.alu = (op == T_R && f7) ? 4'd1 : 4'd0;
               else if (f3 == 3'd1) e.alu = 4'd5;
               else if (f3 == 3'd4) e.alu = 4'd4;
               else if (f3 == 3'd5) e.alu = f7 ? 4'd7 : 4'd6;
               else if (f3 == 3'd6) e.alu = 4'd3;
               else                 e.alu = 4'd2;
            end
         end
         T_LD:   begin e.rf = 1'b1; e.wd = 2'd1; e.re = 4'(mem_w + 1); e.lat = 8'(if_w + 5 + mem_w); end
         T_ST:   begin e.we = 4'(mem_w + 1); e.lat = 8'(if_w + 4 + mem_w); end
         T_BR: begin
            e.alu = 4'd1; e.sel = 1'b0; e.lat = 8'(if_w + 3);
            e.npc = {1'b0, (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) || (f3 == 3'd4 && s) || (f3 == 3'd5 && !s)};
         end
         T_JAL:  begin e.rf = 1'b1; e.wd = 2'd2; e.npc = 2'd1; e.lat = 8'(if_w + 4); end
         T_JALR: begin e.rf = 1'b1; e.wd = 2'd2; e.npc = 2'd2; e.lat = 8'(if_w + 4); end
         T_LUI:  begin e.rf = 1'b1; e.wd = 2'd3; e.lat = 8'(if_w + 4); end
         default: begin e.ill = 1'b1; e.ex_seen = 1'b0; e.lat = 8'(if_w + 2); end
      endcase
      return e;
   endfunction

   // Drive one instruction from its IF cycle to retire; starts and ends at posedge+1
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic z, input logic s, input int if_w, input int mem_w);
      bit done;
      done = 1'b0;
      o_lat = -1; o_ir = 0; o_ir_cyc = -1; o_pc = 0; o_rf = 0; o_re = 0; o_we = 0; o_ill = 0;
      o_unstable = 0; o_npc = 2'bxx; o_wd = 2'bxx; o_alu = 4'bxxxx; o_sel = 1'bx;
      for (int c = 0; c < 40; c++) begin
         opcode = op; funct3 = f3; funct7_5 = f7; alu_zero = z; alu_sgn = s;
         irom_ready = (c >= if_w);
         dram_ready = (c >= if_w + 3 + mem_w);
         #2;
         if (ir_we) begin o_ir++; if (o_ir_cyc < 0) o_ir_cyc = c; end
         if (pc_we)   o_pc++;
         if (rf_we)   o_rf++;
         if (dram_re) o_re++;
         if (dram_we) o_we++;
         if (illegal) o_ill++;
         if (c == if_w + 2) begin o_alu = alu_op; o_sel = alub_sel; end
         else if (c > if_w + 2 && (dram_re || dram_we) && alu_op !== o_alu) o_unstable++;
         if (retire) begin o_npc = npc_op; o_wd = wd_sel; o_lat = c + 1; done = 1'b1; end
         @(posedge clk); #1;
         if (done) break;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; irom_ready = 1'b1; dram_ready = 1'b1; opcode = T_ST; funct3 = 3'd0;
      funct7_5 = 1'b0; alu_zero = 1'b0; alu_sgn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_assert++; if (outs !== 16'h0) begin n_fail++; $display("FAIL reset_outs got %h exp 0000", outs); end
      irom_ready = 1'b0;
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #2;
         n_assert++; if (outs !== 16'h0) begin n_fail++; $display("FAIL idle_outs[%0d] got %h exp 0000", i, outs); end
      end
      @(posedge clk); #1;
      run_instr(T_R, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      n_assert++; if (o_lat !== 4) begin n_fail++; $display("FAIL first_lat got %0d exp 4", o_lat); end
      n_assert++; if (o_pc !== 1) begin n_fail++; $display("FAIL first_pc_we got %0d exp 1", o_pc); end
   endtask

   task automatic test_reset_mid_store;
      opcode = T_ST; funct3 = 3'd2; irom_ready = 1'b1; dram_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      n_assert++; if (dram_we !== 1'b1) begin n_fail++; $display("FAIL mem_dram_we got %b exp 1", dram_we); end
      rst_n = 1'b0;
      #1;
      n_assert++; if (outs !== 16'h0) begin n_fail++; $display("FAIL async_reset got %h exp 0000", outs); end
      @(posedge clk); #2;
      n_assert++; if (ir_we !== 1'b0) begin n_fail++; $display("FAIL reset_ir_we got %b exp 0", ir_we); end
      irom_ready = 1'b0; rst_n = 1'b1;
      @(posedge clk); #2;
      n_assert++; if (outs !== 16'h0) begin n_fail++; $display("FAIL post_reset got %h exp 0000", outs); end
      @(posedge clk); #1;
      run_instr(T_ST, 3'd2, 1'b0, 1'b0, 1'b0, 1, 0);
      n_assert++; if (o_lat !== 5) begin n_fail++; $display("FAIL post_reset_sw_lat got %0d exp 5", o_lat); end
   endtask

   task automatic test_add;
      run_instr(T_R, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      n_assert++; if (o_ir_cyc !== 0) begin n_fail++; $display("FAIL add_ir_cyc got %0d exp 0", o_ir_cyc); end
      n_assert++; if (o_alu !== 4'd0 || o_sel !== 1'b0) begin n_fail++; $display("FAIL add_ex got op=%0d sel=%b exp op=0 sel=0", o_alu, o_sel); end
      n_assert++; if (o_rf !== 1 || o_wd !== 2'd0 || o_pc !== 1) begin n_fail++; $display("FAIL add_wb got rf=%0d wd=%0d pc=%0d exp 1 0 1", o_rf, o_wd, o_pc); end
      n_assert++; if (o_lat !== 4) begin n_fail++; $display("FAIL add_lat got %0d exp 4", o_lat); end
   endtask

   task automatic test_alu_variants;
      run_instr(T_R, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);
      n_assert++; if (o_alu !== 4'd1) begin n_fail++; $display("FAIL sub_op got %0d exp 1", o_alu); end
      run_instr(T_I, 3'd5, 1'b1, 1'b0, 1'b0, 0, 0);
      n_assert++; if (o_alu !== 4'd7 || o_sel !== 1'b1) begin n_fail++; $display("FAIL srai got op=%0d sel=%b exp 7 1", o_alu, o_sel); end
      run_instr(T_I, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);
      n_assert++; if (o_alu !== 4'd0) begin n_fail++; $display("FAIL addi_f7 got %0d exp 0", o_alu); end
   endtask

   task automatic test_branch;
      run_instr(T_BR, 3'd0, 1'b0, 1'b1, 1'b0, 0, 0);
      n_assert++; if (o_npc !== 2'd1 || o_pc !== 1 || o_lat !== 3) begin n_fail++; $display("FAIL beq_taken got npc=%0d pc=%0d lat=%0d exp 1 1 3", o_npc, o_pc, o_lat); end
      run_instr(T_BR, 3'd5, 1'b0, 1'b0, 1'b1, 0, 0);
      n_assert++; if (o_npc !== 2'd0) begin n_fail++; $display("FAIL bge_not_taken got %0d exp 0", o_npc); end
   endtask

   task automatic test_mem_stall;
      run_instr(T_LD, 3'd2, 1'b0, 1'b0, 1'b0, 0, 3);
      n_assert++; if (o_re !== 4 || o_wd !== 2'd1 || o_lat !== 8) begin n_fail++; $display("FAIL lw_stall got re=%0d wd=%0d lat=%0d exp 4 1 8", o_re, o_wd, o_lat); end
      n_assert++; if (o_unstable !== 0) begin n_fail++; $display("FAIL lw_alu_stable got %0d changes exp 0", o_unstable); end
      run_instr(T_ST, 3'd2, 1'b0, 1'b0, 1'b0, 0, 3);
      n_assert++; if (o_we !== 4 || o_rf !== 0 || o_lat !== 7) begin n_fail++; $display("FAIL sw_stall got we=%0d rf=%0d lat=%0d exp 4 0 7", o_we, o_rf, o_lat); end
   endtask

   task automatic test_illegal;
      run_instr(7'b0000000, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      n_assert++; if (o_ill !== 1 || o_pc !== 1 || o_npc !== 2'd0 || o_lat !== 2) begin n_fail++; $display("FAIL ill_id got ill=%0d pc=%0d npc=%0d lat=%0d exp 1 1 0 2", o_ill, o_pc, o_npc, o_lat); end
      n_assert++; if (o_rf !== 0 || o_we !== 0) begin n_fail++; $display("FAIL ill_id_writes got rf=%0d we=%0d exp 0 0", o_rf, o_we); end
      run_instr(T_R, 3'd2, 1'b0, 1'b0, 1'b0, 0, 0);
      n_assert++; if (o_ill !== 1 || o_lat !== 3 || o_rf !== 0) begin n_fail++; $display("FAIL ill_ex got ill=%0d lat=%0d rf=%0d exp 1 3 0", o_ill, o_lat, o_rf); end
   endtask

   task automatic test_random;
      logic [6:0] ops [8];
      logic [6:0] op;
      logic [2:0] f3;
      logic f7, z, s;
      int if_w, mem_w, k;
      exp_t e;
      ops = '{T_R, T_I, T_LD, T_ST, T_BR, T_JAL, T_JALR, T_LUI};
      for (int i = 0; i < 150; i++) begin
         k = $urandom_range(0, 9);
         op = (k < 8) ? ops[k] : 7'($urandom);
         f3 = 3'($urandom); f7 = 1'($urandom); z = 1'($urandom); s = 1'($urandom);
         if_w = $urandom_range(0, 2); mem_w = $urandom_range(0, 3);
         e = model(op, f3, f7, z, s, if_w, mem_w);
         run_instr(op, f3, f7, z, s, if_w, mem_w);
         n_assert++; if (o_lat !== int'(e.lat)) begin n_fail++; $display("FAIL rand_lat[%0d] op=%b f3=%0d got %0d exp %0d", i, op, f3, o_lat, e.lat); end
         n_assert++; if (o_ir !== 1 || o_pc !== 1) begin n_fail++; $display("FAIL rand_ir_pc[%0d] got ir=%0d pc=%0d exp 1 1", i, o_ir, o_pc); end
         n_assert++; if (o_rf !== int'(e.rf) || o_ill !== int'(e.ill)) begin n_fail++; $display("FAIL rand_rf_ill[%0d] got rf=%0d ill=%0d exp %0d %0d", i, o_rf, o_ill, e.rf, e.ill); end
         n_assert++; if (o_re !== int'(e.re) || o_we !== int'(e.we)) begin n_fail++; $display("FAIL rand_mem[%0d] got re=%0d we=%0d exp %0d %0d", i, o_re, o_we, e.re, e.we); end
         n_assert++; if (o_npc !== e.npc) begin n_fail++; $display("FAIL rand_npc[%0d] op=%b got %0d exp %0d", i, op, o_npc, e.npc); end
         if (e.rf) begin
            n_assert++; if (o_wd !== e.wd) begin n_fail++; $display("FAIL rand_wd[%0d] op=%b got %0d exp %0d", i, op, o_wd, e.wd); end
         end
         if (e.ex_seen) begin
            n_assert++; if (o_alu !== e.alu || o_sel !== e.sel) begin n_fail++; $display("FAIL rand_alu[%0d] op=%b f3=%0d f7=%b got %0d/%b exp %0d/%b", i, op, f3, f7, o_alu, o_sel, e.alu, e.sel); end
         end
         n_assert++; if (o_unstable !== 0) begin n_fail++; $display("FAIL rand_stall_alu[%0d] got %0d changes exp 0", i, o_unstable); end
      end
   endtask

   initial begin
      test_reset;
      test_reset_mid_store;
      test_add;
      test_alu_variants;
      test_branch;
      test_mem_stall;
      test_illegal;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
